// File: rtl/ram_access_pkg.sv
// Shared types and default widths for the RAM access initiator.
package ram_access_pkg;

    localparam int RAM_ADDR_W = 16;
    localparam int RAM_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/RAM_2_16x32.sv
// Behavioural model of the RAM_2_16x32 array: writes while write_enable is high at a clock edge,
// read data is presented combinationally while read_enable is high.
module RAM_2_16x32
    import ram_access_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_input,
    output logic [DATA_W-1:0] data_output
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            r_mem[address] <= data_input;
        end
    end

    assign data_output = read_enable ? r_mem[address] : '0;

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response front end for RAM_2_16x32: one access at a time, sequenced setup -> strobe -> hold.
// Latency S+3 cycles from acceptance to rsp_valid; RESP stalls indefinitely on rsp_ready low.
module ram_access_ctrl
    import ram_access_pkg::*;
#(
    parameter int ADDR_W        = RAM_ADDR_W,
    parameter int DATA_W        = RAM_DATA_W,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_input,
    input  logic [DATA_W-1:0] ram_data_output,
    output logic              busy
);

    localparam int             CNT_W       = $clog2(STROBE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_we;
    logic              r_re;
    logic              r_rsp_valid;
    logic              r_req_ready;
    logic              r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_write ? req_wdata : '0;
                        r_rdata     <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_cnt   <= STROBE_LOAD;
                    r_we    <= r_write;
                    r_re    <= ~r_write;
                    r_state <= STROBE;
                end
                STROBE: begin
                    if (r_cnt == CNT_W'(1)) begin
                        // Read data is taken at the edge that closes the final strobe cycle.
                        if (!r_write) begin
                            r_rdata <= ram_data_output;
                        end
                        r_cnt   <= '0;
                        r_we    <= 1'b0;
                        r_re    <= 1'b0;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_we        <= 1'b0;
                    r_re        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready        = r_req_ready;
    assign busy             = r_busy;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_write        = r_write;
    assign rsp_rdata        = r_rdata;
    assign ram_write_enable = r_we;
    assign ram_read_enable  = r_re;
    assign ram_address      = r_addr;
    assign ram_data_input   = r_wdata;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench: two controllers (strobe 1 and strobe 3) each driving its own RAM_2_16x32.
module tb_ram_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_v;
    logic [1:0]       req_valid_v;
    logic [1:0]       req_ready_v;
    logic [1:0]       req_write_v;
    logic [1:0][15:0] req_addr_v;
    logic [1:0][31:0] req_wdata_v;
    logic [1:0]       rsp_valid_v;
    logic [1:0]       rsp_ready_v;
    logic [1:0]       rsp_write_v;
    logic [1:0][31:0] rsp_rdata_v;
    logic [1:0]       we_v;
    logic [1:0]       re_v;
    logic [1:0][15:0] ram_addr_v;
    logic [1:0][31:0] ram_din_v;
    logic [1:0][31:0] ram_dout_v;
    logic [1:0]       busy_v;

    int checks = 0;
    int errors = 0;

    ram_access_ctrl #(.ADDR_W(16), .DATA_W(32), .STROBE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst_v[0]),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]), .req_write(req_write_v[0]),
        .req_addr(req_addr_v[0]), .req_wdata(req_wdata_v[0]),
        .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]), .rsp_write(rsp_write_v[0]),
        .rsp_rdata(rsp_rdata_v[0]),
        .ram_write_enable(we_v[0]), .ram_read_enable(re_v[0]), .ram_address(ram_addr_v[0]),
        .ram_data_input(ram_din_v[0]), .ram_data_output(ram_dout_v[0]), .busy(busy_v[0])
    );

    RAM_2_16x32 u_ram0 (
        .clk(clk), .write_enable(we_v[0]), .read_enable(re_v[0]), .address(ram_addr_v[0]),
        .data_input(ram_din_v[0]), .data_output(ram_dout_v[0])
    );

    ram_access_ctrl #(.ADDR_W(16), .DATA_W(32), .STROBE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst_v[1]),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]), .req_write(req_write_v[1]),
        .req_addr(req_addr_v[1]), .req_wdata(req_wdata_v[1]),
        .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]), .rsp_write(rsp_write_v[1]),
        .rsp_rdata(rsp_rdata_v[1]),
        .ram_write_enable(we_v[1]), .ram_read_enable(re_v[1]), .ram_address(ram_addr_v[1]),
        .ram_data_input(ram_din_v[1]), .ram_data_output(ram_dout_v[1]), .busy(busy_v[1])
    );

    RAM_2_16x32 u_ram1 (
        .clk(clk), .write_enable(we_v[1]), .read_enable(re_v[1]), .address(ram_addr_v[1]),
        .data_input(ram_din_v[1]), .data_output(ram_dout_v[1])
    );

    typedef struct {
        int          u;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        exp_write;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Enables must never overlap, and may only be high while the block is busy.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_v[u]) begin
                check("enable_overlap", 32'(we_v[u] & re_v[u]), 32'd0);
                check("enable_idle", 32'((we_v[u] | re_v[u]) & ~busy_v[u]), 32'd0);
            end
        end
    end

    task automatic check_reset(input int u);
        check("rst_req_ready", 32'(req_ready_v[u]), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_v[u]), 32'd0);
        check("rst_rsp_write", 32'(rsp_write_v[u]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_v[u], 32'd0);
        check("rst_we", 32'(we_v[u]), 32'd0);
        check("rst_re", 32'(re_v[u]), 32'd0);
        check("rst_addr", 32'(ram_addr_v[u]), 32'd0);
        check("rst_din", ram_din_v[u], 32'd0);
        check("rst_busy", 32'(busy_v[u]), 32'd0);
    endtask

    // Returns just after the accepting edge, so the next negedge is in the SETUP cycle.
    task automatic start_req(input int u, input logic wr, input logic [15:0] a,
                             input logic [31:0] d, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        req_valid_v[u] = 1'b1;
        req_write_v[u] = wr;
        req_addr_v[u]  = a;
        req_wdata_v[u] = d;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_v[u]) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            req_valid_v[u] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid_v[u] = 1'b0;
        end
    endtask

    task automatic do_txn(input int u, input logic wr, input logic [15:0] a, input logic [31:0] d,
                          output logic rw, output logic [31:0] rd, output int lat,
                          output int en_cnt, output int en_first, output int wrong_en,
                          output bit addr_ok);
        bit acc;
        rw = 1'b0; rd = '0; lat = -1; en_cnt = 0; en_first = -1; wrong_en = 0; addr_ok = 1'b1;
        start_req(u, wr, a, d, acc);
        if (acc) begin
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (wr ? we_v[u] : re_v[u]) begin
                    en_cnt++;
                    if (en_first < 0) en_first = k;
                end
                if (wr ? re_v[u] : we_v[u]) wrong_en++;
                if (ram_addr_v[u] !== a || ram_din_v[u] !== (wr ? d : 32'd0)) addr_ok = 1'b0;
                if (rsp_valid_v[u]) begin
                    lat = k;
                    rw  = rsp_write_v[u];
                    rd  = rsp_rdata_v[u];
                    break;
                end
            end
            if (lat > 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rw;
        logic [31:0] rd;
        int          lat, en_cnt, en_first, wrong_en, s, k, seen;
        bit          addr_ok, acc;

        vt[0]  = '{0, 1'b1, 16'd66, 32'd20, 1'b1, 32'd0};
        vt[1]  = '{0, 1'b0, 16'd66, 32'd0,  1'b0, 32'd20};
        vt[2]  = '{0, 1'b1, 16'd55, 32'd1,  1'b1, 32'd0};
        vt[3]  = '{0, 1'b1, 16'd66, 32'd20, 1'b1, 32'd0};
        vt[4]  = '{0, 1'b0, 16'd55, 32'd0,  1'b0, 32'd1};
        vt[5]  = '{0, 1'b0, 16'd66, 32'd0,  1'b0, 32'd20};
        vt[6]  = '{0, 1'b1, 16'd70, 32'd12, 1'b1, 32'd0};
        vt[7]  = '{1, 1'b1, 16'd66, 32'd7,  1'b1, 32'd0};
        vt[8]  = '{1, 1'b0, 16'd66, 32'd0,  1'b0, 32'd7};
        vt[9]  = '{1, 1'b1, 16'd3,  32'd5,  1'b1, 32'd0};
        vt[10] = '{1, 1'b0, 16'd3,  32'd0,  1'b0, 32'd5};

        rst_v       = 2'b11;
        req_valid_v = '0;
        req_write_v = '0;
        req_addr_v  = '0;
        req_wdata_v = '0;
        rsp_ready_v = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst_v = 2'b00;

        for (int i = 0; i < 11; i++) begin
            s = (vt[i].u == 0) ? 1 : 3;
            do_txn(vt[i].u, vt[i].wr, vt[i].addr, vt[i].wdata, rw, rd, lat, en_cnt, en_first,
                   wrong_en, addr_ok);
            check($sformatf("v%0d_rsp_write", i), 32'(rw), 32'(vt[i].exp_write));
            check($sformatf("v%0d_rsp_rdata", i), rd, vt[i].exp_rdata);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(s + 3));
            check($sformatf("v%0d_enable_cycles", i), 32'(en_cnt), 32'(s));
            check($sformatf("v%0d_enable_first", i), 32'(en_first), 32'd2);
            check($sformatf("v%0d_wrong_enable", i), 32'(wrong_en), 32'd0);
            check($sformatf("v%0d_addr_data_stable", i), 32'(addr_ok), 32'd1);
        end

        // Backpressure: load 66 with rsp_ready low, and a store pending meanwhile.
        rsp_ready_v[0] = 1'b0;
        start_req(0, 1'b0, 16'd66, 32'd0, acc);
        lat = -1;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid_v[0]) begin
                lat = k;
                break;
            end
        end
        check("bp_latency", 32'(lat), 32'd4);
        req_valid_v[0] = 1'b1;
        req_write_v[0] = 1'b1;
        req_addr_v[0]  = 16'd70;
        req_wdata_v[0] = 32'd99;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid_v[0]), 32'd1);
            check("bp_rsp_rdata", rsp_rdata_v[0], 32'd20);
            check("bp_rsp_write", 32'(rsp_write_v[0]), 32'd0);
            check("bp_req_ready", 32'(req_ready_v[0]), 32'd0);
            @(negedge clk);
        end
        req_valid_v[0] = 1'b0;
        rsp_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_done_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
        check("bp_done_req_ready", 32'(req_ready_v[0]), 32'd1);

        // Reset asserted during the strobe of a load to 55.
        start_req(0, 1'b0, 16'd55, 32'd0, acc);
        @(negedge clk);
        check("rs_setup_re", 32'(re_v[0]), 32'd0);
        @(negedge clk);
        check("rs_strobe_re", 32'(re_v[0]), 32'd1);
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check_reset(0);
        rst_v[0] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_v[0]) seen++;
        end
        check("rs_no_response", 32'(seen), 32'd0);
        do_txn(0, 1'b0, 16'd55, 32'd0, rw, rd, lat, en_cnt, en_first, wrong_en, addr_ok);
        check("rs_reload_rdata", rd, 32'd1);

        // A store pulsed while busy in STROBE must be ignored.
        start_req(0, 1'b0, 16'd55, 32'd0, acc);
        @(negedge clk);
        @(negedge clk);
        check("bi_in_strobe", 32'(re_v[0]), 32'd1);
        req_valid_v[0] = 1'b1;
        req_write_v[0] = 1'b1;
        req_addr_v[0]  = 16'd70;
        req_wdata_v[0] = 32'd99;
        seen = 0;
        lat  = -1;
        for (k = 3; k <= 20; k++) begin
            @(negedge clk);
            req_valid_v[0] = 1'b0;
            if (we_v[0]) seen++;
            if (rsp_valid_v[0]) begin
                lat = k;
                break;
            end
        end
        check("bi_latency", 32'(lat), 32'd4);
        check("bi_no_write", 32'(seen), 32'd0);
        check("bi_rsp_rdata", rsp_rdata_v[0], 32'd1);
        @(posedge clk);
        #1;
        repeat (3) @(negedge clk);
        check("bi_idle_after", 32'(busy_v[0]), 32'd0);
        do_txn(0, 1'b0, 16'd70, 32'd0, rw, rd, lat, en_cnt, en_first, wrong_en, addr_ok);
        check("bi_addr70_rdata", rd, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Synchronous initiator for the `RAM_2_16x32` array. Accepts load/store requests from the CPU datapath over a valid/ready handshake and drives the RAM's level-sensitive `write_enable`/`read_enable`/`address`/`data_input` pins in a safe setup → strobe → hold sequence. For reads it captures `data_output` and returns it over a valid/ready response channel. It sits between the core's memory stage and the RAM instance.

## Interface
- `ADDR_W`, 16, RAM address width
- `DATA_W`, 32, RAM data width
- `STROBE_CYCLES`, 1, cycles an enable is held high; must be ≥ 1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous and active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  word address
- `req_wdata`  in  DATA_W  store data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_write`  out  1  response belongs to a store
- `rsp_rdata`  out  DATA_W  load data; 0 for stores
- `ram_write_enable`  out  1  to RAM `write_enable`
- `ram_read_enable`  out  1  to RAM `read_enable`
- `ram_address`  out  ADDR_W  to RAM `address`
- `ram_data_input`  out  DATA_W  to RAM `data_input`
- `ram_data_output`  in  DATA_W  from RAM `data_output`
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch write, addr, and wdata (wdata is forced to 0 for a load), then go to SETUP.
- SETUP: drive `ram_address`/`ram_data_input` from the latches with both enables low. Lasts 1 cycle, then go to STROBE.
- STROBE: hold `ram_write_enable` (store) or `ram_read_enable` (load) high for exactly STROBE_CYCLES cycles, counted by a down-counter of width $clog2(STROBE_CYCLES+1). On a load, sample `ram_data_output` into the rdata register at the edge that ends the last strobe cycle. Then go to HOLD.
- HOLD: both enables low; address and data unchanged. Lasts 1 cycle, then go to RESP.
- RESP: `rsp_valid`=1 with `rsp_write`/`rsp_rdata` stable. On `rsp_ready`, go to IDLE.
- `ram_write_enable` and `ram_read_enable` are never high together. Neither is ever high outside STROBE.
- `ram_address`/`ram_data_input` change only on the IDLE→SETUP edge. They retain their last value in IDLE.
- `req_valid` outside IDLE is ignored. The requester must hold the request until `req_ready`.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_write`=0, `rsp_rdata`=0, both enables 0, `ram_address`=0, `ram_data_input`=0, `busy`=0, state IDLE, counter 0.
- Handshake at edge N. Then:
  - SETUP runs during cycle N+1.
  - Enable is high during cycles N+2 … N+1+S.
  - HOLD runs during N+2+S.
  - `rsp_valid` rises at N+3+S.
- With S=1, `rsp_valid` is visible 4 cycles after acceptance. The minimum request-to-request spacing is S+4 cycles when `rsp_ready` is tied high.
- Backpressure: RESP persists indefinitely with all outputs stable. No new request is accepted until the response handshake completes.
- Reset mid-operation, from any state: at the next edge every output takes its reset value and the FSM returns to IDLE. The enables drop at that edge. A store aborted in STROBE may or may not have been written; no response is issued.
- `rst` has priority over every handshake in the same cycle.

## Structure
- Package `ram_access_pkg` holds:
  - the FSM state enum (`IDLE`, `SETUP`, `STROBE`, `HOLD`, `RESP`)
  - default-width localparams `RAM_ADDR_W`=16 and `RAM_DATA_W`=32
- No sub-module is natural. The strobe counter and FSM live in one module, `ram_access_ctrl`.
- The bench instantiates `ram_access_ctrl` driving a real `RAM_2_16x32`.

## Test plan
- **Store then load:** store 20 to address 66, then load address 66.
  - `ram_write_enable` is high for exactly 1 cycle, with address 66 and data 20 stable one cycle before and one cycle after.
  - The load response has `rsp_rdata`=20 and `rsp_write`=0.
- **Two addresses:** store 1→55, store 20→66, load 55, load 66.
  - Responses arrive in order: store, store, load=1, load=20.
  - `rsp_valid` appears 4 cycles after each acceptance.
- **Long strobe:** `STROBE_CYCLES`=3.
  - The enable is high for exactly 3 consecutive cycles.
  - `rsp_valid` appears 6 cycles after acceptance.
  - The two enables never overlap at any cycle.
- **Backpressure:** load 66 with `rsp_ready`=0 for 5 cycles.
  - `rsp_valid` and `rsp_rdata`=20 are held stable.
  - `req_ready`=0 throughout, and a pending `req_valid` is not accepted.
  - The response completes on the first `rsp_ready`=1.
- **Reset mid-strobe:** assert `rst` during STROBE of a load to address 55.
  - All outputs return to reset values at the next edge; no `rsp_valid` follows.
  - A subsequent load of 55 returns 1.
- **Busy ignore:** pulse `req_valid` with a store of 99→70 while in STROBE.
  - The request is not accepted and the RAM is not written.
  - A later load of 70 returns the prior contents.
